div_mul_issue: RTL and testbench
================================

Name: div_mul_issue

Overview:
- EX-stage initiator for the shared multicycle divide/multiply unit.
- Decodes DIV/DIVU/MULT/MULTU from EX, latches operands, drives the unit's start/annul/signed/select handshake and holds the pipeline stalled until the unit reports ready.
- Splits the 64-bit unit result into HI/LO write data with a one-cycle write strobe.
- Sits between the EX stage, the div_mul unit and the HI/LO register file.

Parameters:
- TIMEOUT, 40, max cycles in BUSY before the watchdog fires (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- ex_valid_i  in  1  EX holds a valid instruction
- ex_op_i  in  3  000 none, 001 DIV, 010 DIVU, 011 MULT, 100 MULTU, others none
- ex_src1_i  in  32  rs value (dividend / multiplicand)
- ex_src2_i  in  32  rt value (divisor / multiplier)
- flush_i  in  1  kill the in-flight EX instruction (exception/redirect)
- dm_result_i  in  64  unit result
- dm_ready_i  in  1  unit result valid
- dm_start_o  out  1  start request to unit
- dm_annul_o  out  1  cancel request to unit
- dm_signed_o  out  1  signed operation
- dm_choose_o  out  2  01 divide, 11 multiply
- dm_op1_o  out  32  latched operand 1
- dm_op2_o  out  32  latched operand 2
- stallreq_o  out  1  stall request to pipeline control
- hilo_we_o  out  1  HI/LO write strobe
- hi_o  out  32  HI write data
- lo_o  out  32  LO write data
- busy_err_o  out  1  watchdog fired (sticky); present only with the optional feature

Behaviour:
- Reset (rst=0, async) values:
  - state=IDLE.
  - All outputs 0, except dm_choose_o=00.
  - Operand and opcode registers cleared.
- States: IDLE, BUSY, COOL.
- IDLE:
  - Issue condition: ex_valid_i & op in {001..100} & !flush_i.
  - Combinational: stallreq_o=1 whenever the issue condition holds.
  - On the clock edge: latch src1/src2 into dm_op1_o/dm_op2_o; set dm_signed_o (1 for DIV/MULT); set dm_choose_o (01 for DIV/DIVU, 11 for MULT/MULTU); set dm_start_o=1; go to BUSY.
- BUSY:
  - dm_start_o, operands, signed and choose stay constant; the unit re-reads operands in its final cycle.
  - stallreq_o=1 until completion.
  - On dm_ready_i=1:
    - Capture hi_o/lo_o.
    - Divide: hi_o=result[63:32] (remainder), lo_o=result[31:0] (quotient).
    - Multiply: hi_o=result[63:32], lo_o=result[31:0].
    - hilo_we_o=1 for exactly the next cycle; stallreq_o deasserts the same cycle ready is seen.
    - Drop dm_start_o; go to COOL.
  - The controller does not depend on unit latency, nominally about 35 cycles.
- COOL (one cycle):
  - dm_start_o=0 so the unit returns to free; hilo_we_o deasserts at the end of COOL.
  - A new valid op in EX during COOL gets stallreq_o=1 and issues from IDLE on the next cycle.
  - Back-to-back minimum issue spacing: BUSY exit → COOL → IDLE → BUSY.
- Flush:
  - flush_i in BUSY: dm_annul_o=1 and dm_start_o=0 for one cycle, no HI/LO write, stallreq_o=0, go to COOL.
  - flush_i in IDLE: prevents issue.
  - flush_i coinciding with dm_ready_i: flush wins; no write.
- Divide by zero: handled entirely by the unit; the controller writes whatever result the unit returns.
- dm_annul_o is 0 except during the flush pulse.

Optional Feature:
- Macro DM_WATCHDOG_EN.
- Defined:
  - A counter clears on BUSY entry and increments each BUSY cycle.
  - At TIMEOUT it behaves as a flush (annul pulse, no write, go to COOL), sets busy_err_o (sticky until reset) and releases stall.
- Undefined: no counter, no busy_err_o port; BUSY waits indefinitely.

Test Plan:
- DIVU 100/7 → after ready, hilo_we_o one cycle; HI=0x00000002, LO=0x0000000E; stall high from issue until ready.
- DIV 0xFFFFFFF9 / 0x00000002 (−7/2) → dm_signed_o=1, dm_choose_o=01; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MULTU 0xFFFFFFFF×2 → HI=0x00000001, LO=0xFFFFFFFE. MULT 0xFFFFFFFD×5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- Change ex_src1_i/ex_src2_i every cycle while BUSY → dm_op1_o/dm_op2_o stay at issue values; result matches the issue operands.
- flush_i at BUSY cycle 10 → dm_annul_o pulse, no hilo_we_o, stall drops that cycle. Next DIVU 9/3 → HI=0, LO=3.
- rst low mid-BUSY → all outputs 0 immediately. With DM_WATCHDOG_EN, TIMEOUT=8, and a unit model never asserting ready → annul at BUSY cycle 8, busy_err_o=1, no write.

Source files
------------

// File: rtl/div_mul_issue_if.sv
// -----------------------------------------------------------------------------
// div_mul_issue_if
// Handshake bundle between the EX-stage issue controller and the shared
// multicycle divide/multiply unit.
//   dm_start_o   controller -> unit  start request (held for the whole op)
//   dm_annul_o   controller -> unit  one-cycle cancel pulse
//   dm_signed_o  controller -> unit  signed operation
//   dm_choose_o  controller -> unit  01 divide, 11 multiply
//   dm_op1_o     controller -> unit  latched operand 1 (dividend/multiplicand)
//   dm_op2_o     controller -> unit  latched operand 2 (divisor/multiplier)
//   dm_result_i  unit -> controller  {HI, LO} result
//   dm_ready_i   unit -> controller  result valid
// Signal suffixes are written from the controller's point of view.
// -----------------------------------------------------------------------------
interface div_mul_issue_if;
  logic        dm_start_o;
  logic        dm_annul_o;
  logic        dm_signed_o;
  logic [1:0]  dm_choose_o;
  logic [31:0] dm_op1_o;
  logic [31:0] dm_op2_o;
  logic [63:0] dm_result_i;
  logic        dm_ready_i;

  // Issue controller side
  modport master (
    output dm_start_o, dm_annul_o, dm_signed_o, dm_choose_o, dm_op1_o, dm_op2_o,
    input  dm_result_i, dm_ready_i
  );

  // Divide/multiply unit side
  modport slave (
    input  dm_start_o, dm_annul_o, dm_signed_o, dm_choose_o, dm_op1_o, dm_op2_o,
    output dm_result_i, dm_ready_i
  );
endinterface

// File: rtl/div_mul_issue.sv
// -----------------------------------------------------------------------------
// div_mul_issue
// EX-stage initiator for the shared multicycle divide/multiply unit. Decodes
// DIV/DIVU/MULT/MULTU, latches operands, runs the start/annul handshake on the
// unit, stalls the pipeline until the unit is ready and produces a one-cycle
// HI/LO write strobe with the split 64-bit result.
//
// Optional feature: define DM_WATCHDOG_EN to add a BUSY watchdog. After TIMEOUT
// cycles in BUSY the operation is cancelled like a flush and busy_err_o is set.
// -----------------------------------------------------------------------------
module div_mul_issue #(
    parameter int unsigned TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    input  logic [2:0]  ex_op_i,
    input  logic [31:0] ex_src1_i,
    input  logic [31:0] ex_src2_i,
    input  logic        flush_i,
    input  logic [63:0] dm_result_i,
    input  logic        dm_ready_i,
    output logic        dm_start_o,
    output logic        dm_annul_o,
    output logic        dm_signed_o,
    output logic [1:0]  dm_choose_o,
    output logic [31:0] dm_op1_o,
    output logic [31:0] dm_op2_o,
    output logic        stallreq_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
`ifdef DM_WATCHDOG_EN
    output logic        busy_err_o,
`endif
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        COOL = 2'b10
    } state_e;

    localparam logic [2:0] OP_DIV   = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_MULT  = 3'b011;
    localparam logic [2:0] OP_MULTU = 3'b100;

    state_e      state_r;
    logic        start_r;
    logic        annul_r;
    logic        signed_r;
    logic [1:0]  choose_r;
    logic [31:0] op1_r;
    logic [31:0] op2_r;
    logic        we_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic        is_muldiv_s;
    logic        is_div_s;
    logic        issue_ok_s;
    logic        wd_fire_s;
    logic        kill_s;
    logic        stall_s;

`ifdef DM_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_r;
    logic          err_r;

    // Watchdog fires during the TIMEOUT-th BUSY cycle
    always_comb begin
        if ((state_r == BUSY) && (cnt_r == CW'(TIMEOUT - 1))) begin
            wd_fire_s = 1'b1;
        end else begin
            wd_fire_s = 1'b0;
        end
    end

    // BUSY cycle counter and sticky watchdog error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CW{1'b0}};
            err_r <= 1'b0;
        end else begin
            if (state_r == BUSY) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= {CW{1'b0}};
            end
            if (wd_fire_s && !flush_i) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign busy_err_o = err_r;
`else
    assign wd_fire_s = 1'b0;
`endif

    // Decode and combinational stall request
    always_comb begin
        is_muldiv_s = 1'b0;
        is_div_s    = 1'b0;
        stall_s     = 1'b0;
        case (ex_op_i)
            OP_DIV, OP_DIVU: begin
                is_muldiv_s = 1'b1;
                is_div_s    = 1'b1;
            end
            OP_MULT, OP_MULTU: begin
                is_muldiv_s = 1'b1;
                is_div_s    = 1'b0;
            end
            default: begin
                is_muldiv_s = 1'b0;
                is_div_s    = 1'b0;
            end
        endcase
        issue_ok_s = ex_valid_i & is_muldiv_s & ~flush_i;
        kill_s     = flush_i | wd_fire_s;
        case (state_r)
            IDLE:    stall_s = issue_ok_s;
            COOL:    stall_s = issue_ok_s;
            BUSY:    stall_s = ~kill_s & ~dm_ready_i;
            default: stall_s = 1'b0;
        endcase
    end

    // Issue FSM with registered handshake and HI/LO outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            start_r  <= 1'b0;
            annul_r  <= 1'b0;
            signed_r <= 1'b0;
            choose_r <= 2'b00;
            op1_r    <= 32'd0;
            op2_r    <= 32'd0;
            we_r     <= 1'b0;
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    annul_r <= 1'b0;
                    we_r    <= 1'b0;
                    if (issue_ok_s) begin
                        op1_r    <= ex_src1_i;
                        op2_r    <= ex_src2_i;
                        signed_r <= (ex_op_i == OP_DIV) || (ex_op_i == OP_MULT);
                        choose_r <= is_div_s ? 2'b01 : 2'b11;
                        start_r  <= 1'b1;
                        state_r  <= BUSY;
                    end else begin
                        start_r  <= 1'b0;
                    end
                end
                BUSY: begin
                    if (kill_s) begin
                        annul_r <= 1'b1;
                        start_r <= 1'b0;
                        we_r    <= 1'b0;
                        state_r <= COOL;
                    end else if (dm_ready_i) begin
                        hi_r    <= dm_result_i[63:32];
                        lo_r    <= dm_result_i[31:0];
                        we_r    <= 1'b1;
                        start_r <= 1'b0;
                        state_r <= COOL;
                    end else begin
                        start_r <= 1'b1;
                    end
                end
                COOL: begin
                    start_r <= 1'b0;
                    annul_r <= 1'b0;
                    we_r    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    start_r <= 1'b0;
                    annul_r <= 1'b0;
                    we_r    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign dm_start_o  = start_r;
    assign dm_annul_o  = annul_r;
    assign dm_signed_o = signed_r;
    assign dm_choose_o = choose_r;
    assign dm_op1_o    = op1_r;
    assign dm_op2_o    = op2_r;
    assign stallreq_o  = stall_s;
    assign hilo_we_o   = we_r;
    assign hi_o        = hi_r;
    assign lo_o        = lo_r;

endmodule

// File: tb/tb_div_mul_issue.sv
// -----------------------------------------------------------------------------
// tb_div_mul_issue
// Self-checking bench for div_mul_issue. The bench plays the EX stage and the
// divide/multiply unit; expected HI/LO come from an arithmetic reference model
// of the instruction set. Define DM_WATCHDOG_EN to exercise the watchdog.
// -----------------------------------------------------------------------------
module tb_div_mul_issue;

  localparam int TO = 8;
`ifdef DM_WATCHDOG_EN
  localparam bit WD      = 1'b1;
  localparam int LAT_MAX = 7;
  localparam int FL_AT   = 5;
`else
  localparam bit WD      = 1'b0;
  localparam int LAT_MAX = 36;
  localparam int FL_AT   = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [2:0]  ex_op = 3'd0;
  logic [31:0] src1 = 32'd0;
  logic [31:0] src2 = 32'd0;
  logic        flush = 1'b0;
  logic        stall;
  logic        we;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy_err;

  always #5 clk = ~clk;

  div_mul_issue_if dmif();

  div_mul_issue #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid_i  (ex_valid),
    .ex_op_i     (ex_op),
    .ex_src1_i   (src1),
    .ex_src2_i   (src2),
    .flush_i     (flush),
    .dm_result_i (dmif.dm_result_i),
    .dm_ready_i  (dmif.dm_ready_i),
    .dm_start_o  (dmif.dm_start_o),
    .dm_annul_o  (dmif.dm_annul_o),
    .dm_signed_o (dmif.dm_signed_o),
    .dm_choose_o (dmif.dm_choose_o),
    .dm_op1_o    (dmif.dm_op1_o),
    .dm_op2_o    (dmif.dm_op2_o),
    .stallreq_o  (stall),
    .hilo_we_o   (we),
    .hi_o        (hi),
`ifdef DM_WATCHDOG_EN
    .busy_err_o  (busy_err),
`endif
    .lo_o        (lo)
  );

`ifndef DM_WATCHDOG_EN
  assign busy_err = 1'b0;
`endif

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;
  logic        exp_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: what the instruction architecturally writes as {HI, LO}
  function automatic logic [63:0] ref_hilo(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] up;
    case (op)
      3'd1, 3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sa = (op == 3'd1) ? longint'($signed(a)) : longint'({32'd0, a});
        sb = (op == 3'd1) ? longint'($signed(b)) : longint'({32'd0, b});
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
      end
      3'd4: begin
        up = {32'd0, a} * {32'd0, b};
        return up;
      end
      default: return 64'd0;
    endcase
  endfunction

  // Unit model: computes from whatever the controller presents on the bus
  function automatic logic [63:0] unit_calc(input logic sgn, input logic [1:0] ch,
                                            input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] xa, xb, q, r;
    xa = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    xb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    if (ch == 2'b11) return xa * xb;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    q = xa / xb;
    r = xa % xb;
    return {r[31:0], q[31:0]};
  endfunction

  logic [2:0]  nxt_op;
  logic [31:0] nxt_a, nxt_b;

  // One full operation from IDLE; lat=0 means the unit never answers.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el,
                       input int lat, input int fl_at, input bit chg, input bit b2b);
    bit done, rdy, fl, wdf, killed;
    logic exp_sgn;
    logic [1:0] exp_ch;
    done = 1'b0; rdy = 1'b0; fl = 1'b0; wdf = 1'b0;
    exp_sgn = (op == 3'd1) || (op == 3'd3);
    exp_ch  = (op <= 3'd2) ? 2'b01 : 2'b11;
    ex_valid = 1'b1; ex_op = op; src1 = a; src2 = b; flush = 1'b0;
    dmif.dm_ready_i = 1'b0;
    #1;
    chk("idle_start", dmif.dm_start_o, 1'b0);
    chk("issue_stall", stall, 1'b1);
    @(posedge clk); #1;
    for (int k = 1; k <= LAT_MAX + TO + 2; k++) begin
      chk("busy_start", dmif.dm_start_o, 1'b1);
      chk("busy_annul", dmif.dm_annul_o, 1'b0);
      chk("op1_hold", dmif.dm_op1_o, a);
      chk("op2_hold", dmif.dm_op2_o, b);
      chk("signed", dmif.dm_signed_o, exp_sgn);
      chk("choose", dmif.dm_choose_o, exp_ch);
      chk("busy_we", we, 1'b0);
      if (chg) begin
        src1 = $urandom;
        src2 = $urandom;
      end
      rdy = (k == lat);
      fl  = (k == fl_at);
      wdf = WD && (k == TO);
      dmif.dm_ready_i  = rdy;
      flush            = fl;
      dmif.dm_result_i = rdy ? unit_calc(dmif.dm_signed_o, dmif.dm_choose_o, dmif.dm_op1_o, dmif.dm_op2_o)
                             : {$urandom, $urandom};
      #1;
      chk("busy_stall", stall, !(rdy || fl || wdf));
      done = rdy || fl || wdf;
      @(posedge clk); #1;
      if (done) break;
    end
    if (!done) chk("op_end_bound", 1'b0, 1'b1);
    killed = fl || wdf;
    if (wdf && !fl) exp_err = 1'b1;
    chk("cool_we", we, !killed);
    chk("cool_annul", dmif.dm_annul_o, killed);
    chk("cool_start", dmif.dm_start_o, 1'b0);
    if (!killed) begin
      last_hi = eh;
      last_lo = el;
    end
    chk("hi", hi, last_hi);
    chk("lo", lo, last_lo);
    chk("busy_err", busy_err, WD && exp_err);
    dmif.dm_ready_i = 1'b0;
    flush = 1'b0;
    if (b2b) begin
      ex_valid = 1'b1; ex_op = nxt_op; src1 = nxt_a; src2 = nxt_b;
    end else begin
      ex_valid = 1'b0; ex_op = 3'd0;
    end
    #1;
    chk("cool_stall", stall, b2b);
    @(posedge clk); #1;
    chk("idle_we", we, 1'b0);
    chk("idle_annul", dmif.dm_annul_o, 1'b0);
  endtask

  // An EX cycle that must not issue
  task automatic no_issue(input logic v, input logic [2:0] op, input logic fl);
    ex_valid = v; ex_op = op; src1 = $urandom; src2 = $urandom; flush = fl;
    #1;
    chk("noissue_stall", stall, 1'b0);
    @(posedge clk); #1;
    chk("noissue_start", dmif.dm_start_o, 1'b0);
    ex_valid = 1'b0; ex_op = 3'd0; flush = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, dmif.dm_start_o, 1'b0);
    chk({tag, "_annul"}, dmif.dm_annul_o, 1'b0);
    chk({tag, "_signed"}, dmif.dm_signed_o, 1'b0);
    chk({tag, "_choose"}, dmif.dm_choose_o, 2'b00);
    chk({tag, "_op1"}, dmif.dm_op1_o, 32'd0);
    chk({tag, "_op2"}, dmif.dm_op2_o, 32'd0);
    chk({tag, "_stall"}, stall, 1'b0);
    chk({tag, "_we"}, we, 1'b0);
    chk({tag, "_hi"}, hi, 32'd0);
    chk({tag, "_lo"}, lo, 32'd0);
    chk({tag, "_err"}, busy_err, 1'b0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] e;
    int          lat, fl_at;
    dmif.dm_ready_i  = 1'b0;
    dmif.dm_result_i = 64'd0;
    #1 rst = 1'b0;
    #1 chk_all_zero("reset");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    do_op(3'd2, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, LAT_MAX, 0, 1'b0, 1'b0);
    do_op(3'd1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 5, 0, 1'b0, 1'b0);
    nxt_op = 3'd3; nxt_a = 32'hFFFF_FFFD; nxt_b = 32'd5;
    do_op(3'd4, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 3, 0, 1'b0, 1'b1);
    do_op(3'd3, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1, 0, 1'b0, 1'b0);
    do_op(3'd2, 32'd1000, 32'd10, 32'd0, 32'd100, 6, 0, 1'b1, 1'b0);
    do_op(3'd1, 32'd1234, 32'd5, 32'd0, 32'd0, LAT_MAX, FL_AT, 1'b0, 1'b0);
    do_op(3'd2, 32'd9, 32'd3, 32'd0, 32'd3, 4, 0, 1'b0, 1'b0);
    do_op(3'd3, 32'd7, 32'd9, 32'd0, 32'd0, 3, 3, 1'b0, 1'b0);
    e = ref_hilo(3'd2, 32'd55, 32'd0);
    do_op(3'd2, 32'd55, 32'd0, e[63:32], e[31:0], 2, 0, 1'b0, 1'b0);

    no_issue(1'b1, 3'd0, 1'b0);
    no_issue(1'b1, 3'd5, 1'b0);
    no_issue(1'b1, 3'd7, 1'b0);
    no_issue(1'b1, 3'd1, 1'b1);
    no_issue(1'b0, 3'd3, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom_range(1, 4));
      a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : 32'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
      lat = $urandom_range(1, LAT_MAX);
      fl_at = ($urandom_range(0, 5) == 0) ? $urandom_range(1, lat) : 0;
      e = ref_hilo(op, a, b);
      do_op(op, a, b, e[63:32], e[31:0], lat, fl_at, 1'($urandom_range(0, 1)), 1'b0);
    end

    ex_valid = 1'b1; ex_op = 3'd4; src1 = 32'hDEAD_BEEF; src2 = 32'd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst_busy", dmif.dm_start_o, 1'b1);
    ex_valid = 1'b0; ex_op = 3'd0;
    rst = 1'b0;
    #1 chk_all_zero("midrst");
    @(posedge clk); #1 rst = 1'b1;
    last_hi = 32'd0; last_lo = 32'd0; exp_err = 1'b0;
    @(posedge clk); #1;
    e = ref_hilo(3'd3, 32'h8000_0000, 32'h8000_0000);
    do_op(3'd3, 32'h8000_0000, 32'h8000_0000, e[63:32], e[31:0], 2, 0, 1'b0, 1'b0);

`ifdef DM_WATCHDOG_EN
    do_op(3'd2, 32'd77, 32'd7, 32'd0, 32'd0, 0, 0, 1'b0, 1'b0);
    e = ref_hilo(3'd1, 32'd77, 32'hFFFF_FFF9);
    do_op(3'd1, 32'd77, 32'hFFFF_FFF9, e[63:32], e[31:0], 3, 0, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
